// File: rtl/pc_seq_ctrl_if.sv
// pc_seq_ctrl_if: ready-handshaked program-memory read port between the
// fetch sequencer (master) and program memory (slave).
interface pc_seq_ctrl_if;
   logic       mem_rd;
   logic       mem_ready;
   logic [7:0] mem_rdata;
   modport master (output mem_rd, input mem_ready, input mem_rdata);
   modport slave (input mem_rd, output mem_ready, output mem_rdata);
endinterface

// File: rtl/pc_seq_ctrl.sv
// pc_seq_ctrl: instruction-fetch sequencer driving PC_counter loads/increments,
// instruction register capture, branch operand fetch and the ALU execute strobe.
module pc_seq_ctrl #(
   parameter logic [7:0] RESET_VEC = 8'h00
) (
   input  logic                 sys_clk,
   input  logic                 sys_rst,
   pc_seq_ctrl_if.master        mem,
   input  logic                 start,
   input  logic                 zero_flag,
   output logic                 LOAD,
   output logic                 LDPC,
   output logic [7:0]           load_addr,
   output logic [7:0]           ir,
   output logic                 alu_en,
   output logic                 busy,
   output logic                 halted,
   output logic [2:0]           state_o
);
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      INIT   = 3'd1,
      FETCH  = 3'd2,
      DECODE = 3'd3,
      OPER   = 3'd4,
      EXEC   = 3'd5,
      HALT   = 3'd6
   } state_t;

   localparam logic [3:0] OP_NOP = 4'h0;
   localparam logic [3:0] OP_JMP = 4'h1;
   localparam logic [3:0] OP_JZ  = 4'h2;
   localparam logic [3:0] OP_HLT = 4'hF;

   state_t     state;
   logic [3:0] op;
   logic       is_jump;

   assign op      = ir[7:4];
   assign is_jump = op == OP_JMP || op == OP_JZ;

   always_ff @(posedge sys_clk or negedge sys_rst) begin
      if (!sys_rst) begin
         state     <= IDLE;
         ir        <= 8'h00;
         load_addr <= 8'h00;
      end else begin
         case (state)
            IDLE: if (start) begin
               state     <= INIT;
               load_addr <= RESET_VEC;
            end
            INIT: state <= FETCH;
            FETCH: if (mem.mem_ready) begin
               ir    <= mem.mem_rdata;
               state <= DECODE;
            end
            DECODE: state <= is_jump ? OPER : (op == OP_HLT) ? HALT : EXEC;
            OPER: if (mem.mem_ready) begin
               load_addr <= mem.mem_rdata;
               state     <= EXEC;
            end
            EXEC: state <= FETCH;
            HALT: if (start) state <= FETCH;
            default: state <= IDLE;
         endcase
      end
   end

   // Strobes decode the registered state; LDPC must track mem_ready in the accepting cycle.
   assign mem.mem_rd = state == FETCH || state == OPER;
   assign LDPC       = mem.mem_rd && mem.mem_ready;
   assign LOAD       = state == INIT ||
                       (state == EXEC && (op == OP_JMP || (op == OP_JZ && zero_flag)));
   assign alu_en     = state == EXEC && !is_jump && op != OP_NOP && op != OP_HLT;
   assign busy       = state != IDLE && state != HALT;
   assign halted     = state == HALT;
   assign state_o    = state;
endmodule

// File: tb/tb_pc_seq_ctrl.sv
// tb_pc_seq_ctrl: directed cycle table plus randomized programs checked against
// an instruction-level model of the fetch sequencer and a PC_counter model.
module tb_pc_seq_ctrl;
   logic       sys_clk = 1'b0;
   logic       sys_rst = 1'b1;
   logic       start = 1'b0;
   logic       zero_flag = 1'b0;
   logic       LOAD, LDPC, alu_en, busy, halted;
   logic [7:0] load_addr, ir;
   logic [2:0] state_o;

   pc_seq_ctrl_if bus ();

   pc_seq_ctrl #(.RESET_VEC(8'h10)) dut (
      .sys_clk   (sys_clk),
      .sys_rst   (sys_rst),
      .mem       (bus),
      .start     (start),
      .zero_flag (zero_flag),
      .LOAD      (LOAD),
      .LDPC      (LDPC),
      .load_addr (load_addr),
      .ir        (ir),
      .alu_en    (alu_en),
      .busy      (busy),
      .halted    (halted),
      .state_o   (state_o)
   );

   always #5 sys_clk = ~sys_clk;

   logic [7:0] prog [256];
   logic [7:0] pc = 8'h00;
   logic [7:0] pc_nxt = 8'h00;
   assign bus.mem_rdata = prog[pc];

   // PC_counter model: strobes sampled mid-cycle, applied on the next rising edge
   always @(negedge sys_clk) pc_nxt = LOAD ? load_addr : LDPC ? pc + 8'd1 : pc;
   always @(posedge sys_clk) pc <= pc_nxt;

   int tests = 0;
   int fails = 0;

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%h exp=%h", nm, got, exp);
      end
   endtask

   always @(negedge sys_clk) if (sys_rst) begin
      tests++;
      assert (!(LOAD && LDPC)) else begin
         fails++;
         $display("FAIL load_ldpc_excl LOAD=%b LDPC=%b", LOAD, LDPC);
      end
   end

   bit         mon = 1'b0;
   int         busy_cyc, wait_cyc, alu_cnt;
   logic [7:0] q_acc [$];
   logic [7:0] q_ld [$];

   always @(negedge sys_clk) if (mon) begin
      if (busy) busy_cyc++;
      if (bus.mem_rd && !bus.mem_ready) wait_cyc++;
      if (alu_en) alu_cnt++;
      if (bus.mem_rd && bus.mem_ready) q_acc.push_back(pc);
      if (LOAD) q_ld.push_back(load_addr);
      tests++;
      if (LDPC !== (bus.mem_rd && bus.mem_ready)) begin
         fails++;
         $display("FAIL ldpc_handshake got=%b exp=%b", LDPC, bus.mem_rd && bus.mem_ready);
      end
   end

   typedef struct packed {
      logic       start, rdy, zf;
      logic [2:0] st;
      logic       rd, ld, ldpc, alu;
      logic [7:0] la, ir, pc;
   } vec_t;
   vec_t tbl [$];

   task automatic row(input logic s, r, z, input logic [2:0] st, input logic rd, ld, lp, al,
                      input logic [7:0] la, irv, p);
      tbl.push_back('{s, r, z, st, rd, ld, lp, al, la, irv, p});
   endtask

   logic [7:0] ea [$];
   logic [7:0] eld [$];
   int         ealu, ecyc;

   // Instruction-level reference: walk the program, one entry per fetched byte and per PC load.
   task automatic model(input logic z);
      logic [7:0] p, b;
      p = 8'h10;
      ea.delete();
      eld.delete();
      eld.push_back(8'h10);
      ealu = 0;
      ecyc = 1;
      for (int n = 0; n < 200; n++) begin
         b = prog[p];
         ea.push_back(p);
         if (b[7:4] == 4'hF) begin
            ecyc += 2;
            break;
         end
         if (b[7:4] == 4'h1 || b[7:4] == 4'h2) begin
            ea.push_back(p + 8'd1);
            ecyc += 4;
            if (b[7:4] == 4'h1 || z) begin
               eld.push_back(prog[p + 8'd1]);
               p = prog[p + 8'd1];
            end else p = p + 8'd2;
         end else begin
            ecyc += 3;
            if (b[7:4] != 4'h0) ealu++;
            p = p + 8'd1;
         end
      end
   endtask

   // Two-byte slots from 0x10 to 0x3F, forward even jump targets, HLT everywhere else.
   task automatic build_prog();
      logic [3:0] opc;
      int k, pos;
      for (int i = 0; i < 256; i++) prog[i] = {4'hF, 4'($urandom)};
      pos = 16;
      while (pos < 64) begin
         k = int'($urandom_range(0, 9));
         opc = k == 0 ? 4'h0 : k == 1 ? 4'h1 : k == 2 ? 4'h2 : k == 3 ? 4'hF :
               4'($urandom_range(3, 14));
         prog[pos] = {opc, 4'($urandom)};
         prog[pos + 1] = (opc == 4'h1 || opc == 4'h2) ?
                         8'(pos + 2 + 2 * int'($urandom_range(0, (62 - pos) / 2))) :
                         {4'h0, 4'($urandom)};
         pos += 2;
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.mem_ready = 1'b0;
      for (int i = 0; i < 256; i++) prog[i] = 8'h00;
      prog[8'h11] = 8'h10; prog[8'h12] = 8'h40;
      prog[8'h40] = 8'h20; prog[8'h41] = 8'h80;
      prog[8'h42] = 8'h20; prog[8'h43] = 8'h80;
      prog[8'h80] = 8'h35; prog[8'h81] = 8'hF0;
      prog[8'h82] = 8'h11; prog[8'h83] = 8'h20;

      row(1,1,0, 3'd0, 0,0,0,0, 8'h00, 8'h00, 8'h00);
      row(0,1,0, 3'd1, 0,1,0,0, 8'h10, 8'h00, 8'h00);
      row(0,1,0, 3'd2, 1,0,1,0, 8'h10, 8'h00, 8'h10);
      row(1,1,0, 3'd3, 0,0,0,0, 8'h10, 8'h00, 8'h11);
      row(0,1,0, 3'd5, 0,0,0,0, 8'h10, 8'h00, 8'h11);
      row(0,1,0, 3'd2, 1,0,1,0, 8'h10, 8'h00, 8'h11);
      row(0,1,0, 3'd3, 0,0,0,0, 8'h10, 8'h10, 8'h12);
      row(0,1,0, 3'd4, 1,0,1,0, 8'h10, 8'h10, 8'h12);
      row(1,1,0, 3'd5, 0,1,0,0, 8'h40, 8'h10, 8'h13);
      row(0,1,0, 3'd2, 1,0,1,0, 8'h40, 8'h10, 8'h40);
      row(0,1,0, 3'd3, 0,0,0,0, 8'h40, 8'h20, 8'h41);
      row(0,1,0, 3'd4, 1,0,1,0, 8'h40, 8'h20, 8'h41);
      row(0,1,0, 3'd5, 0,0,0,0, 8'h80, 8'h20, 8'h42);
      row(0,1,0, 3'd2, 1,0,1,0, 8'h80, 8'h20, 8'h42);
      row(1,1,0, 3'd3, 0,0,0,0, 8'h80, 8'h20, 8'h43);
      row(0,1,1, 3'd4, 1,0,1,0, 8'h80, 8'h20, 8'h43);
      row(0,1,1, 3'd5, 0,1,0,0, 8'h80, 8'h20, 8'h44);
      row(0,0,0, 3'd2, 1,0,0,0, 8'h80, 8'h20, 8'h80);
      row(0,0,0, 3'd2, 1,0,0,0, 8'h80, 8'h20, 8'h80);
      row(0,0,0, 3'd2, 1,0,0,0, 8'h80, 8'h20, 8'h80);
      row(0,1,0, 3'd2, 1,0,1,0, 8'h80, 8'h20, 8'h80);
      row(0,1,0, 3'd3, 0,0,0,0, 8'h80, 8'h35, 8'h81);
      row(0,1,0, 3'd5, 0,0,0,1, 8'h80, 8'h35, 8'h81);
      row(0,1,0, 3'd2, 1,0,1,0, 8'h80, 8'h35, 8'h81);
      row(0,1,0, 3'd3, 0,0,0,0, 8'h80, 8'hF0, 8'h82);
      row(0,1,0, 3'd6, 0,0,0,0, 8'h80, 8'hF0, 8'h82);
      row(1,1,0, 3'd6, 0,0,0,0, 8'h80, 8'hF0, 8'h82);
      row(0,1,0, 3'd2, 1,0,1,0, 8'h80, 8'hF0, 8'h82);
      row(0,1,0, 3'd3, 0,0,0,0, 8'h80, 8'h11, 8'h83);
      row(0,0,0, 3'd4, 1,0,0,0, 8'h80, 8'h11, 8'h83);

      #1 sys_rst = 1'b0;
      #2 chk("reset_state", 64'({state_o, bus.mem_rd, LOAD, LDPC, alu_en, busy, halted, load_addr, ir}), 64'd0);
      @(posedge sys_clk); #1;
      sys_rst = 1'b1;

      for (int i = 0; i < tbl.size(); i++) begin
         start = tbl[i].start;
         bus.mem_ready = tbl[i].rdy;
         zero_flag = tbl[i].zf;
         @(negedge sys_clk);
         chk($sformatf("vec%0d", i),
             64'({state_o, bus.mem_rd, LOAD, LDPC, alu_en, busy, halted, load_addr, ir, pc}),
             64'({tbl[i].st, tbl[i].rd, tbl[i].ld, tbl[i].ldpc, tbl[i].alu,
                  tbl[i].st != 3'd0 && tbl[i].st != 3'd6, tbl[i].st == 3'd6,
                  tbl[i].la, tbl[i].ir, tbl[i].pc}));
         if (i != tbl.size() - 1) begin
            @(posedge sys_clk); #1;
         end
      end

      // Reset lands mid-OPER with the operand read still outstanding.
      #2 sys_rst = 1'b0;
      #1 chk("rst_async", 64'({state_o, bus.mem_rd, LOAD, LDPC, alu_en, busy, halted, load_addr, ir}), 64'd0);
      bus.mem_ready = 1'b1;
      start = 1'b1;
      @(negedge sys_clk);
      chk("rst_no_ldpc", 64'({LDPC, LOAD, bus.mem_rd}), 64'd0);
      @(posedge sys_clk); #1;
      chk("rst_pc_hold", 64'({state_o, pc}), 64'({3'd0, 8'h83}));
      start = 1'b0;
      sys_rst = 1'b1;

      for (int run = 0; run < 6; run++) begin
         int cyc;
         sys_rst = 1'b0;
         start = 1'b0;
         bus.mem_ready = 1'b0;
         @(posedge sys_clk); #1;
         sys_rst = 1'b1;
         build_prog();
         zero_flag = run[0];
         model(zero_flag);
         q_acc.delete();
         q_ld.delete();
         busy_cyc = 0;
         wait_cyc = 0;
         alu_cnt = 0;
         mon = 1'b1;
         start = 1'b1;
         bus.mem_ready = $urandom_range(0, 3) != 0;
         cyc = 0;
         forever begin
            @(negedge sys_clk);
            if (halted) break;
            if (cyc++ > 3000) begin
               tests++;
               fails++;
               $display("FAIL run%0d_timeout got=not_halted exp=halted", run);
               break;
            end
            @(posedge sys_clk); #1;
            start = 1'($urandom_range(0, 1));
            bus.mem_ready = $urandom_range(0, 3) != 0;
         end
         start = 1'b0;
         #1 mon = 1'b0;
         chk($sformatf("run%0d_acc_n", run), 64'(q_acc.size()), 64'(ea.size()));
         for (int i = 0; i < ea.size() && i < q_acc.size(); i++)
            chk($sformatf("run%0d_acc%0d", run, i), 64'(q_acc[i]), 64'(ea[i]));
         chk($sformatf("run%0d_ld_n", run), 64'(q_ld.size()), 64'(eld.size()));
         for (int i = 0; i < eld.size() && i < q_ld.size(); i++)
            chk($sformatf("run%0d_ld%0d", run, i), 64'(q_ld[i]), 64'(eld[i]));
         chk($sformatf("run%0d_alu", run), 64'(alu_cnt), 64'(ealu));
         chk($sformatf("run%0d_cycles", run), 64'(busy_cyc), 64'(ecyc + wait_cyc));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/pc_seq_ctrl.md
# pc_seq_ctrl

Instruction-fetch sequencer that drives the PC_counter block of the 8-bit CPU. It is a small FSM that loads the PC reset vector, fetches each instruction byte over a ready-handshaked memory read port, and pulses PC increment (LDPC). It decodes the opcode nibble, fetches a branch operand byte when the instruction needs one, and issues PC loads (LOAD/load_addr) for jumps. It sits between program memory and PC_counter, and also issues the one-cycle execute strobe to the ALU path.

## Interface
- RESET_VEC, 8'h00, address loaded into the PC when leaving IDLE
- sys_clk  in  1  system clock, all state changes on rising edge
- sys_rst  in  1  asynchronous, active-low reset
- start  in  1  leave IDLE or resume from HALT, sampled each clock
- mem_rdata  in  8  program memory read data, valid when mem_ready=1
- mem_ready  in  1  memory handshake, read completes on an edge where mem_rd=1 and mem_ready=1
- zero_flag  in  1  ALU zero flag, sampled in EXEC for JZ
- mem_rd  out  1  read request, held until accepted
- LOAD  out  1  PC load strobe, to PC_counter
- LDPC  out  1  PC increment strobe, to PC_counter
- load_addr  out  8  PC load value, to PC_counter
- ir  out  8  instruction register
- alu_en  out  1  one-cycle execute strobe for non-control opcodes
- busy  out  1  high in every state except IDLE and HALT
- halted  out  1  high in HALT
- state_o  out  3  current state encoding, for debug

## Operation
- States and encoding: IDLE=0, INIT=1, FETCH=2, DECODE=3, OPER=4, EXEC=5, HALT=6. Code 7 is illegal and goes to IDLE.
- Opcodes use ir[7:4]: 0x0 NOP, 0x1 JMP, 0x2 JZ, 0xF HLT. All other values are 1-byte ALU ops.
- IDLE: all strobes are 0. When start=1, go to INIT.
- INIT: load_addr<=RESET_VEC is registered on the IDLE->INIT edge. LOAD=1 for this one cycle. Go to FETCH.
- FETCH: mem_rd=1. While mem_ready=0, stay in FETCH. On the mem_ready=1 edge: ir<=mem_rdata, LDPC=1 during that cycle (combinational from state and mem_ready), go to DECODE.
- DECODE: one cycle, no strobes. JMP or JZ goes to OPER. HLT goes to HALT. Everything else goes to EXEC.
- OPER: mem_rd=1 and wait for mem_ready. On the accepting edge: load_addr<=mem_rdata, LDPC=1 so the PC skips the operand byte, go to EXEC.
- EXEC, by opcode:
  - ALU op: alu_en=1.
  - NOP: no strobe.
  - JMP: LOAD=1.
  - JZ: LOAD=zero_flag.
  - Always go to FETCH next.
- HALT: halted=1, no strobes. When start=1, go to FETCH and resume at the current PC.
- LOAD and LDPC are never high in the same cycle. A bench assertion must check this.
- mem_rd is high only in FETCH and OPER.
- load_addr keeps its value until the next INIT or OPER capture.
- start is ignored in every state except IDLE and HALT.

## Timing
- Reset (async, sys_rst=0):
  - state=IDLE; ir=8'h00; load_addr=8'h00.
  - mem_rd, LOAD, LDPC, alu_en, busy and halted are all 0; state_o=0.
  - Takes effect immediately, in any state including mid-handshake. An outstanding mem_rd drops at once, and no LOAD/LDPC pulse follows.
- Zero-wait memory (mem_ready=1):
  - NOP or ALU instruction: 3 cycles (FETCH, DECODE, EXEC).
  - JMP or JZ: 4 cycles (FETCH, DECODE, OPER, EXEC).
  - HLT: 2 cycles to HALT.
- Each wait cycle (mem_ready=0) adds exactly one cycle in FETCH or OPER, with all strobes 0 except mem_rd.
- mem_ready while mem_rd=0 is ignored.
- Exactly one LDPC per accepted byte.
- From start sampled in IDLE to the first mem_rd: 2 edges (IDLE->INIT->FETCH).
- The PC reflects LOAD and LDPC on the same edge the strobe is sampled. FETCH directly after EXEC therefore reads the jump target.
- PC wrap-around (0xFF->0x00) belongs to PC_counter. The sequencer has no address-range checks.

## Test plan
- Reset vector: RESET_VEC=8'h10, start pulse, mem_ready=1 -> LOAD=1 with load_addr=8'h10 in INIT (state_o=1), then mem_rd=1 in the next cycle.
- NOP stream: mem_rdata=8'h00, mem_ready=1 -> LDPC pulses every 3 cycles; PC advances 0x10, 0x11, 0x12; LOAD never asserts.
- JMP: bytes 8'h10 then 8'h40 -> LDPC pulses in FETCH and OPER; LOAD=1 with load_addr=8'h40 in EXEC; next fetch address is 0x40.
- JZ both ways: 8'h20 then 8'h80:
  - zero_flag=0 -> no LOAD, PC = old+2.
  - zero_flag=1 -> LOAD with 8'h80.
- Wait states and ALU op: 8'h35 with mem_ready low for 3 cycles -> mem_rd held for 4 cycles, one LDPC, ir=8'h35, alu_en for exactly 1 cycle.
- HLT, resume and mid-op reset:
  - 8'hF0 -> halted=1 and busy=0; start -> FETCH with no LOAD.
  - sys_rst=0 asserted in OPER with mem_ready=0 -> all outputs reset immediately; no LDPC issued.
